// File: rtl/io_char_arbiter_pkg.sv
// Shared types and constants for the I/O input-character arbiter.
package io_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, PRESENT, RELEASE} arb_state_t;

  localparam int CHAR_W_DEF = 5;

  localparam int DEV_TYPE  = 0;
  localparam int DEV_PHOTO = 1;
  localparam int DEV_CARD  = 2;
  localparam int DEV_MAG   = 3;

endpackage

// File: rtl/io_char_arbiter_if.sv
// Character handshake between the arbiter (master) and the I/O section (slave).
import io_arb_pkg::*;

interface io_char_arbiter_if #(
  parameter int CHAR_W = CHAR_W_DEF,
  parameter int SRC_W  = 2
);
  logic              CHAR_VALID;
  logic [CHAR_W-1:0] CHAR_CODE;
  logic [SRC_W-1:0]  CHAR_SRC;
  logic              CHAR_TAKEN;

  modport master (output CHAR_VALID, output CHAR_CODE, output CHAR_SRC, input CHAR_TAKEN);
  modport slave  (input CHAR_VALID, input CHAR_CODE, input CHAR_SRC, output CHAR_TAKEN);
endinterface

// File: rtl/io_char_arbiter_rr_pick.sv
// Combinational winner select: round-robin after i_ptr, or lowest index wins
// when IO_ARB_FIXED_PRIO_EN is defined (the pointer port then disappears).
import io_arb_pkg::*;

module io_rr_pick #(
  parameter int N_DEV = 4,
  parameter int IW    = 2
) (
  input  logic [N_DEV-1:0] i_req,
`ifndef IO_ARB_FIXED_PRIO_EN
  input  logic [IW-1:0]    i_ptr,
`endif
  output logic             o_any,
  output logic [IW-1:0]    o_idx
);

`ifdef IO_ARB_FIXED_PRIO_EN
  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IW'(i);
    end
  end
`else
  // Scan from farthest to nearest so the nearest requester after i_ptr wins.
  always_comb begin
    int j;
    j     = 0;
    o_any = |i_req;
    o_idx = '0;
    for (int k = N_DEV; k >= 1; k--) begin
      j = (int'(i_ptr) + k) % N_DEV;
      if (i_req[j]) o_idx = IW'(j);
    end
  end
`endif

endmodule

// File: rtl/io_char_arbiter.sv
// Input-character arbiter: grants on T0, presents the latched char, acks or times out.
// IO_ARB_FIXED_PRIO_EN selects fixed priority (lowest index) instead of round-robin.
import io_arb_pkg::*;

module io_char_arbiter #(
  parameter int N_DEV      = 4,
  parameter int CHAR_W     = CHAR_W_DEF,
  parameter int TIMEOUT_WT = 1024
) (
  input  logic                    CLOCK,
  input  logic                    rst,
  input  logic                    T0,
  input  logic                    IN,
  input  logic [N_DEV-1:0]        dev_req,
  input  logic [N_DEV*CHAR_W-1:0] dev_code,
  output logic [N_DEV-1:0]        dev_ack,
  output logic                    TIMEOUT,
  io_char_arbiter_if.master       cbus
);

  localparam int SRC_W = $clog2(N_DEV);
  localparam int CNT_W = $clog2(TIMEOUT_WT + 1);

  arb_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_any;
  logic [SRC_W-1:0]  w_idx;
  logic [CHAR_W-1:0] w_code;
  logic              w_src_req;

`ifndef IO_ARB_FIXED_PRIO_EN
  logic [SRC_W-1:0]  r_ptr;
`endif

  io_rr_pick #(.N_DEV(N_DEV), .IW(SRC_W)) u_pick (
    .i_req (dev_req),
`ifndef IO_ARB_FIXED_PRIO_EN
    .i_ptr (r_ptr),
`endif
    .o_any (w_any),
    .o_idx (w_idx)
  );

  assign w_code    = dev_code[w_idx*CHAR_W +: CHAR_W];
  assign w_src_req = dev_req[cbus.CHAR_SRC];

  always_ff @(posedge CLOCK) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      dev_ack         <= '0;
      TIMEOUT         <= 1'b0;
      cbus.CHAR_VALID <= 1'b0;
      cbus.CHAR_CODE  <= '0;
      cbus.CHAR_SRC   <= '0;
`ifndef IO_ARB_FIXED_PRIO_EN
      r_ptr           <= SRC_W'(N_DEV - 1);
`endif
    end else begin
      dev_ack <= '0;
      TIMEOUT <= 1'b0;
      case (r_state)
        IDLE: begin
          if (T0 && IN && w_any) begin
            cbus.CHAR_CODE <= w_code;
            cbus.CHAR_SRC  <= w_idx;
            r_state        <= GRANT;
          end
        end
        GRANT: begin
          if (!IN) begin
            r_state <= IDLE;
          end else begin
            r_state         <= PRESENT;
            cbus.CHAR_VALID <= 1'b1;
            r_cnt           <= '0;
          end
        end
        PRESENT: begin
          // Taken is checked before the timeout so a coincident terminal T0 still acks.
          if (!IN) begin
            r_state         <= IDLE;
            cbus.CHAR_VALID <= 1'b0;
          end else if (cbus.CHAR_TAKEN) begin
            r_state                <= RELEASE;
            cbus.CHAR_VALID        <= 1'b0;
            dev_ack[cbus.CHAR_SRC] <= 1'b1;
`ifndef IO_ARB_FIXED_PRIO_EN
            r_ptr                  <= cbus.CHAR_SRC;
`endif
          end else if (T0) begin
            if (r_cnt == CNT_W'(TIMEOUT_WT - 1)) begin
              r_state         <= RELEASE;
              cbus.CHAR_VALID <= 1'b0;
              TIMEOUT         <= 1'b1;
`ifndef IO_ARB_FIXED_PRIO_EN
              r_ptr           <= cbus.CHAR_SRC;
`endif
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        RELEASE: begin
          if (!w_src_req) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_char_arbiter.sv
// Scoreboard bench for io_char_arbiter (TIMEOUT_WT=4); expected grants/acks queued by stimulus.
import io_arb_pkg::*;

module tb_io_char_arbiter;

  logic        CLOCK = 1'b0;
  logic        rst   = 1'b0;
  logic        T0    = 1'b0;
  logic        IN    = 1'b0;
  logic [3:0]  dev_req = 4'b0000;
  logic [19:0] dev_code;
  logic [3:0]  dev_ack;
  logic        TIMEOUT;

  logic [4:0]  codes [4] = '{5'h11, 5'h12, 5'h1A, 5'h13};
  assign dev_code = {codes[3], codes[2], codes[1], codes[0]};

  io_char_arbiter_if #(.CHAR_W(5), .SRC_W(2)) cbus ();

  io_char_arbiter #(.N_DEV(4), .CHAR_W(5), .TIMEOUT_WT(4)) dut (
    .CLOCK    (CLOCK),
    .rst      (rst),
    .T0       (T0),
    .IN       (IN),
    .dev_req  (dev_req),
    .dev_code (dev_code),
    .dev_ack  (dev_ack),
    .TIMEOUT  (TIMEOUT),
    .cbus     (cbus)
  );

  always #5 CLOCK = ~CLOCK;

  int n_chk = 0;
  int n_fail = 0;
  logic [6:0] grant_q [$];
  logic [3:0] ack_q [$];
  int n_to_exp = 0;
  int n_to_seen = 0;
  logic       prev_valid = 1'b0;
  logic [3:0] prev_ack = 4'b0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a char, an ack or a timeout.
  always @(negedge CLOCK) begin
    if (cbus.CHAR_VALID && !prev_valid) begin
      if (grant_q.size() == 0) chk("grant_unexpected", grant_q.size(), 1);
      else begin
        logic [6:0] e;
        e = grant_q.pop_front();
        chk("grant_src", {30'd0, cbus.CHAR_SRC}, {30'd0, e[6:5]});
        chk("grant_code", {27'd0, cbus.CHAR_CODE}, {27'd0, e[4:0]});
      end
    end
    if (dev_ack != 4'b0000) begin
      chk("ack_single_cycle", {28'd0, prev_ack}, 0);
      if (ack_q.size() == 0) chk("ack_unexpected", {28'd0, dev_ack}, 0);
      else chk("ack_value", {28'd0, dev_ack}, {28'd0, ack_q.pop_front()});
    end
    if (TIMEOUT) begin
      chk("timeout_expected", n_to_seen + 1, n_to_exp);
      n_to_seen <= n_to_seen + 1;
    end
    prev_valid <= cbus.CHAR_VALID;
    prev_ack   <= dev_ack;
  end

  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic t0_pulse;
    tick; T0 = 1'b1;
    tick; T0 = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, cbus.CHAR_VALID}, 0);
    chk({tag, "_code"}, {27'd0, cbus.CHAR_CODE}, 0);
    chk({tag, "_src"}, {30'd0, cbus.CHAR_SRC}, 0);
    chk({tag, "_ack"}, {28'd0, dev_ack}, 0);
    chk({tag, "_timeout"}, {31'd0, TIMEOUT}, 0);
  endtask

  // Grant, take on the first PRESENT cycle, then drop (and optionally re-raise) the request.
  task automatic xfer(input int src, input bit reraise);
    grant_q.push_back({2'(src), codes[src]});
    ack_q.push_back(4'(1 << src));
    t0_pulse;
    tick;
    cbus.CHAR_TAKEN = 1'b1;
    tick;
    cbus.CHAR_TAKEN = 1'b0;
    @(negedge CLOCK);
    chk("valid_drop_on_take", {31'd0, cbus.CHAR_VALID}, 0);
    tick; dev_req[src] = 1'b0;
    tick; tick;
    if (reraise) dev_req[src] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [5];
    int w, nxt;
`ifdef IO_ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0, 0};
    w = 0; nxt = 1;
`else
    order = '{0, 1, 2, 3, 0};
    w = 1; nxt = 2;
`endif
    cbus.CHAR_TAKEN = 1'b0;

    // Reset state
    repeat (3) tick;
    @(negedge CLOCK);
    chk_reset_outputs("reset");
    tick; rst = 1'b1; IN = 1'b1;

    // Single device, latency and one-cycle ack
    dev_req = 4'b0100;
    grant_q.push_back({2'd2, 5'h1A});
    ack_q.push_back(4'b0100);
    t0_pulse;
    @(negedge CLOCK); chk("lat_1clk_valid", {31'd0, cbus.CHAR_VALID}, 0);
    @(negedge CLOCK); chk("lat_2clk_valid", {31'd0, cbus.CHAR_VALID}, 1);
    tick; cbus.CHAR_TAKEN = 1'b1;
    tick; cbus.CHAR_TAKEN = 1'b0;
    @(negedge CLOCK);
    chk("single_valid_low", {31'd0, cbus.CHAR_VALID}, 0);
    chk("single_ack", {28'd0, dev_ack}, 32'h4);
    @(negedge CLOCK); chk("single_ack_done", {28'd0, dev_ack}, 0);
    tick; dev_req = 4'b0000; tick; tick;

    // Round-robin order from a fresh reset
    rst = 1'b0; tick; tick; rst = 1'b1;
    dev_req = 4'b1111;
    for (int i = 0; i < 5; i++) xfer(order[i], 1'b1);

    // Timeout on the 4th T0 in PRESENT, then grant moves to another requester
    grant_q.push_back({2'(w), codes[w]});
    n_to_exp++;
    t0_pulse;
    tick;
    repeat (3) t0_pulse;
    @(negedge CLOCK);
    chk("no_early_timeout", {31'd0, TIMEOUT}, 0);
    chk("valid_before_timeout", {31'd0, cbus.CHAR_VALID}, 1);
    t0_pulse;
    @(negedge CLOCK);
    chk("timeout_pulse", {31'd0, TIMEOUT}, 1);
    chk("timeout_valid_low", {31'd0, cbus.CHAR_VALID}, 0);
    tick; dev_req[w] = 1'b0; tick; tick;
    xfer(nxt, 1'b1);
    dev_req = 4'b0000;

    // CHAR_TAKEN coincides with the terminal T0
    dev_req = 4'b1000;
    grant_q.push_back({2'd3, codes[3]});
    ack_q.push_back(4'b1000);
    t0_pulse;
    tick;
    repeat (3) t0_pulse;
    tick; T0 = 1'b1; cbus.CHAR_TAKEN = 1'b1;
    tick; T0 = 1'b0; cbus.CHAR_TAKEN = 1'b0;
    @(negedge CLOCK);
    chk("collision_no_timeout", {31'd0, TIMEOUT}, 0);
    chk("collision_ack", {28'd0, dev_ack}, 32'h8);
    tick; dev_req = 4'b0000; tick; tick;

    // IN dropped while PRESENT, then the same device wins again
    dev_req = 4'b0110;
    grant_q.push_back({2'd1, codes[1]});
    t0_pulse;
    tick; IN = 1'b0;
    @(negedge CLOCK); chk("abort_valid_held", {31'd0, cbus.CHAR_VALID}, 1);
    tick;
    @(negedge CLOCK);
    chk("abort_valid_low", {31'd0, cbus.CHAR_VALID}, 0);
    chk("abort_no_ack", {28'd0, dev_ack}, 0);
    tick; IN = 1'b1;
    xfer(1, 1'b0);
    dev_req = 4'b0000;

    // Reset during PRESENT, no grant until a fresh T0
    dev_req = 4'b0100;
    grant_q.push_back({2'd2, codes[2]});
    t0_pulse;
    tick; rst = 1'b0;
    tick; rst = 1'b1;
    @(negedge CLOCK);
    chk_reset_outputs("midreset");
    repeat (6) tick;
    @(negedge CLOCK); chk("no_grant_without_t0", {31'd0, cbus.CHAR_VALID}, 0);
    xfer(2, 1'b0);
    dev_req = 4'b0000;

    repeat (3) tick;
    @(negedge CLOCK);
    chk("grant_q_drained", grant_q.size(), 0);
    chk("ack_q_drained", ack_q.size(), 0);
    chk("timeout_total", n_to_seen, n_to_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
